// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed hex display driven from captured CPU debug registers.
// A captured page is latched into a frame register only at frame boundaries,
// so a displayed frame never mixes digits from two different captures.
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned SEG_ACT_LOW  = 1,
  parameter int unsigned SEL_ACT_LOW  = 1,
  parameter int unsigned LZ_BLANK     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dr,
  input  logic [15:0] pc,
  input  logic [7:0]  cr,
  input  logic        load,
  input  logic [1:0]  page,
  output logic [7:0]  seg,
  output logic [3:0]  segsel
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_P   = PW'(BLANK_CYCLES);
  localparam logic [7:0]    SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]    SEL_OFF   = (SEL_ACT_LOW != 0) ? 4'hF : 4'h0;

  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [31:0]   cap_dr;
  logic [15:0]   cap_pc;
  logic [7:0]    cap_cr;
  logic [15:0]   frame;
  logic [1:0]    frame_page;

  logic          wrap_c;
  logic [15:0]   page_val_c;
  logic [3:0]    nib_c;
  logic          upper_zero_c;
  logic [7:0]    pat_c;
  logic [3:0]    onehot_c;
  logic [7:0]    seg_nxt_c;
  logic [3:0]    segsel_nxt_c;

  // Hex nibble to active-high gfedcba glyph
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Next display pattern from current scan position and frame contents
  always_comb begin
    wrap_c       = (presc == PRESC_MAX);
    page_val_c   = 16'h0000;
    upper_zero_c = 1'b0;
    case (page)
      2'd0:    page_val_c = cap_dr[15:0];
      2'd1:    page_val_c = cap_dr[31:16];
      2'd2:    page_val_c = cap_pc;
      default: page_val_c = {cap_cr, 8'h00};
    endcase
    case (digit)
      2'd1:    upper_zero_c = (frame[15:4] == 12'h000);
      2'd2:    upper_zero_c = (frame[15:8] == 8'h00);
      2'd3:    upper_zero_c = (frame[15:12] == 4'h0);
      default: upper_zero_c = 1'b0;
    endcase
    nib_c    = frame[{digit, 2'b00} +: 4];
    pat_c    = {(digit == frame_page), hex_glyph(nib_c)};
    if ((LZ_BLANK != 0) && upper_zero_c) begin
      pat_c[6:0] = 7'h00;
    end
    onehot_c     = 4'b0001 << digit;
    seg_nxt_c    = (SEG_ACT_LOW != 0) ? ~pat_c : pat_c;
    segsel_nxt_c = (SEL_ACT_LOW != 0) ? ~onehot_c : onehot_c;
    if (presc < BLANK_P) begin
      seg_nxt_c    = SEG_OFF;
      segsel_nxt_c = SEL_OFF;
    end
  end

  // Scan counters, capture/frame registers and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc      <= '0;
      digit      <= 2'd0;
      cap_dr     <= 32'h0;
      cap_pc     <= 16'h0;
      cap_cr     <= 8'h0;
      frame      <= 16'h0;
      frame_page <= 2'd0;
      seg        <= SEG_OFF;
      segsel     <= SEL_OFF;
    end else begin
      presc <= wrap_c ? '0 : presc + PW'(1);
      if (wrap_c) begin
        digit <= digit + 2'd1;
        if (digit == 2'd3) begin
          frame      <= page_val_c;
          frame_page <= page;
        end
      end
      if (load) begin
        cap_dr <= dr;
        cap_pc <= pc;
        cap_cr <= cr;
      end
      seg    <= seg_nxt_c;
      segsel <= segsel_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a plain and a leading-zero-blanking instance
// share stimulus and are compared each cycle against a counter-based model.
module tb_seg7_scan_display;

  localparam int unsigned SD    = 8;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dr;
  logic [15:0] pc;
  logic [7:0]  cr;
  logic        load;
  logic [1:0]  page;
  logic [7:0]  seg0, seg1;
  logic [3:0]  segsel0, segsel1;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset, captured regs, displayed frame
  int unsigned k;
  logic [31:0] m_dr;
  logic [15:0] m_pc;
  logic [7:0]  m_cr;
  logic [15:0] m_frame;
  logic [1:0]  m_fpage;
  logic [7:0]  exp_seg0, exp_seg1;
  logic [3:0]  exp_sel;
  int          dig_shown, presc_shown;
  logic [15:0] frame_shown;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BLK), .SEG_ACT_LOW(1),
                      .SEL_ACT_LOW(1), .LZ_BLANK(0)) dut (
    .clk(clk), .reset(reset), .dr(dr), .pc(pc), .cr(cr), .load(load),
    .page(page), .seg(seg0), .segsel(segsel0));

  seg7_scan_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BLK), .SEG_ACT_LOW(1),
                      .SEL_ACT_LOW(1), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .reset(reset), .dr(dr), .pc(pc), .cr(cr), .load(load),
    .page(page), .seg(seg1), .segsel(segsel1));

  always #5 clk = ~clk;

  function automatic logic [15:0] page_sel(input logic [1:0] p);
    case (p)
      2'd0:    return m_dr[15:0];
      2'd1:    return m_dr[31:16];
      2'd2:    return m_pc;
      default: return {m_cr, 8'h00};
    endcase
  endfunction

  // Predict what the next edge shows, advance the model, then clock the DUTs
  task automatic tick();
    int pos, pr, dg;
    logic [15:0] upper;
    logic [7:0]  pat0, pat1;
    exp_seg0 = 8'hFF; exp_seg1 = 8'hFF; exp_sel = 4'hF;
    dig_shown = -1; presc_shown = -1; frame_shown = m_frame;
    if (reset) begin
      pos = int'(k % FRAME); pr = pos % SD; dg = pos / SD;
      dig_shown = dg; presc_shown = pr;
      if (pr >= BLK) begin
        upper = m_frame >> (4 * dg);
        pat0  = {(dg == int'(m_fpage)), glyph_tab[upper[3:0]]};
        pat1  = pat0;
        if (dg > 0 && upper == 16'h0) pat1[6:0] = 7'h00;
        exp_seg0 = ~pat0; exp_seg1 = ~pat1;
        exp_sel  = ~(4'b0001 << dg);
      end
    end
    if (!reset) begin
      k = 0; m_dr = 0; m_pc = 0; m_cr = 0; m_frame = 0; m_fpage = 0;
    end else begin
      if (k % FRAME == FRAME - 1) begin
        m_frame = page_sel(page); m_fpage = page;
      end
      if (load) begin
        m_dr = dr; m_pc = pc; m_cr = cr;
      end
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; page = 2'd0; dr = '0; pc = '0; cr = '0;
    repeat (3) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {8'hFF, 8'hFF, 4'hF, 4'hF}) begin
        errors++;
        $display("FAIL reset_outputs got seg=%h/%h sel=%h/%h exp FF/FF F/F", seg0, seg1, segsel0, segsel1);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL first_frame cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      if (i >= 1 && i <= FRAME) begin
        checks++;
        if (presc_shown >= int'(BLK) && seg0 !== ~{(dig_shown == 0), 7'h3F}) begin
          errors++;
          $display("FAIL first_frame_zero dig=%0d got %h", dig_shown, seg0);
        end
      end
    end
  endtask

  task automatic test_load_page0();
    dr = 32'hFFFF_FFFC; page = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL load_page0 cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      if (frame_shown == 16'hFFFC && presc_shown >= int'(BLK)) begin
        checks++;
        if (seg0 !== ((dig_shown == 0) ? ~8'hB9 : ~8'h71)) begin
          errors++;
          $display("FAIL load_page0_glyph dig=%0d got %h", dig_shown, seg0);
        end
      end
    end
  endtask

  task automatic test_page2_lz();
    pc = 16'h0006; page = 2'd2; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL page2 cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      if (frame_shown == 16'h0006 && presc_shown >= int'(BLK)) begin
        checks++;
        case (dig_shown)
          0: if (seg0 !== ~8'h7D || seg1 !== ~8'h7D) begin
               errors++; $display("FAIL page2_dig0 got %h/%h exp %h", seg0, seg1, ~8'h7D);
             end
          2: if (seg0 !== ~8'hBF || seg1 !== 8'h7F) begin
               errors++; $display("FAIL page2_dig2 got %h/%h exp %h/7f", seg0, seg1, ~8'hBF);
             end
          default: if (seg0 !== ~8'h3F || seg1 !== 8'hFF) begin
               errors++; $display("FAIL page2_dig%0d got %h/%h exp %h/ff", dig_shown, seg0, seg1, ~8'h3F);
             end
        endcase
      end
    end
  endtask

  task automatic test_load_at_boundary();
    logic        found;
    logic [15:0] want;
    logic [3:0]  nib;
    page = 2'd0; dr = 32'h0000_1234; load = 1'b1;
    tick();
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (k % FRAME == FRAME - 1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL boundary_wait got no frame edge exp within %0d", 2 * FRAME);
    end
    dr = 32'h0000_ABCD; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL boundary cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      if ((i % SD) >= BLK) begin
        want = (i < FRAME) ? 16'h1234 : 16'hABCD;
        want = want >> (4 * ((i % FRAME) / SD));
        nib  = want[3:0];
        checks++;
        if (seg0[6:0] !== ~glyph_tab[nib]) begin
          errors++;
          $display("FAIL boundary_glyph cyc=%0d got %h exp %h", i, seg0[6:0], ~glyph_tab[nib]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (k % FRAME == 2 * SD + 4) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midreset_wait got no digit2 exp within %0d", 2 * FRAME);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({seg0, segsel0, segsel1} !== {8'hFF, 4'hF, 4'hF}) begin
      errors++; $display("FAIL midreset_outputs got %h %h/%h exp ff f/f", seg0, segsel0, segsel1);
    end
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL midreset cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      if (i >= 1 && i <= FRAME && presc_shown >= int'(BLK)) begin
        checks++;
        if (seg0 !== ~{(dig_shown == 0), 7'h3F}) begin
          errors++; $display("FAIL midreset_zero dig=%0d got %h", dig_shown, seg0);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      dr    = $urandom;
      pc    = 16'($urandom);
      cr    = 8'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) page = 2'($urandom);
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) dr[31:8] = '0;
      tick();
      checks++;
      if ({seg0, seg1, segsel0, segsel1} !== {exp_seg0, exp_seg1, exp_sel, exp_sel}) begin
        errors++;
        $display("FAIL random cyc=%0d got %h/%h %h/%h exp %h/%h %h", i, seg0, seg1, segsel0, segsel1, exp_seg0, exp_seg1, exp_sel);
      end
      checks++;
      if ($countones(~segsel0) > 1 || $countones(~segsel1) > 1 ||
          (presc_shown >= 0 && presc_shown < int'(BLK) && segsel0 !== 4'hF)) begin
        errors++;
        $display("FAIL random_onehot cyc=%0d got %h/%h exp at most one low", i, segsel0, segsel1);
      end
    end
    reset = 1'b1; load = 1'b0;
  endtask

  initial begin
    k = 0; m_dr = 0; m_pc = 0; m_cr = 0; m_frame = 0; m_fpage = 0;
    test_reset();
    test_first_frame();
    test_load_page0();
    test_page2_lz();
    test_load_at_boundary();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
